// File: rtl/opcode_pipe_if.sv
// ============================================================================
// opcode_pipe_if : fetch/flush inputs and per-stage opcode outputs of opcode_pipe
// Optional: OPCODE_PIPE_STALL_COUNT_EN adds stall_count. Revision: 1.0
// ============================================================================
`default_nettype none

interface opcode_pipe_if;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        flush;
    logic [3:0]  opcode_id;
    logic [3:0]  opcode_ex;
    logic [3:0]  opcode_mem;
    logic [3:0]  opcode_wb;
    logic [3:0]  function_code_wb;
    logic        stall;
    logic        halted;
`ifdef OPCODE_PIPE_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    modport master (
        output instr_in, instr_valid, flush,
        input  opcode_id, opcode_ex, opcode_mem, opcode_wb, function_code_wb,
        input  stall, halted
`ifdef OPCODE_PIPE_STALL_COUNT_EN
        , input stall_count
`endif
    );

    modport slave (
        input  instr_in, instr_valid, flush,
        output opcode_id, opcode_ex, opcode_mem, opcode_wb, function_code_wb,
        output stall, halted
`ifdef OPCODE_PIPE_STALL_COUNT_EN
        , output stall_count
`endif
    );
endinterface

`default_nettype wire

// File: rtl/opcode_pipe.sv
// ============================================================================
// opcode_pipe : ID/EX/MEM/WB opcode pipeline with load-use stall, flush, HALT drain
// Optional: OPCODE_PIPE_STALL_COUNT_EN adds a saturating stall counter. Revision: 1.0
// ============================================================================
`default_nettype none

module opcode_pipe #(
    parameter logic [3:0] NOP_OP  = 4'b1000,
    parameter logic [3:0] HALT_OP = 4'b1111,
    parameter logic [3:0] LBU_OP  = 4'b0100,
    parameter logic [3:0] LW_OP   = 4'b0110
) (
    input  wire logic    clk,
    input  wire logic    rst,
    opcode_pipe_if.slave bus
);

    localparam logic [15:0] c_bubble     = {NOP_OP, 12'h000};
    localparam logic [7:0]  c_bubble_opf = {NOP_OP, 4'h0};

    // ID/EX keep {op, op1, op2, func}; past EX the register fields feed nothing,
    // so MEM/WB carry only {op, func}.
    logic [15:0] r_id;
    logic [15:0] r_ex;
    logic [7:0]  r_mem;
    logic [7:0]  r_wb;
    logic        r_halted;

    logic [15:0] w_id_nxt;
    logic [15:0] w_ex_nxt;
    logic        w_halt_hold;
    logic        w_hazard;
    logic        w_stall;
    logic        w_halted_nxt;

    always_comb begin
        w_halt_hold = (r_id[15:12] == HALT_OP);
        w_hazard    = ((r_ex[15:12] == LBU_OP) || (r_ex[15:12] == LW_OP)) &&
                      (r_id[15:12] != NOP_OP) &&
                      ((r_ex[11:8] == r_id[11:8]) || (r_ex[11:8] == r_id[7:4]));
        w_stall     = w_hazard && !bus.flush && !w_halt_hold;

        w_id_nxt = bus.instr_valid ? bus.instr_in : c_bubble;
        w_ex_nxt = r_id;
        if (bus.flush) begin
            w_id_nxt = c_bubble;
            w_ex_nxt = c_bubble;
        end else if (w_halt_hold || w_hazard) begin
            w_id_nxt = r_id;
            w_ex_nxt = c_bubble;
        end

        // Evaluated on next-state values so halted rises with the drained pipe.
        w_halted_nxt = r_halted ||
                       ((w_id_nxt[15:12] == HALT_OP) && (w_ex_nxt[15:12] == NOP_OP) &&
                        (r_ex[15:12] == NOP_OP) && (r_mem[7:4] == NOP_OP));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id     <= c_bubble;
            r_ex     <= c_bubble;
            r_mem    <= c_bubble_opf;
            r_wb     <= c_bubble_opf;
            r_halted <= 1'b0;
        end else begin
            r_id     <= w_id_nxt;
            r_ex     <= w_ex_nxt;
            r_mem    <= {r_ex[15:12], r_ex[3:0]};
            r_wb     <= r_mem;
            r_halted <= w_halted_nxt;
        end
    end

    assign bus.opcode_id        = r_id[15:12];
    assign bus.opcode_ex        = r_ex[15:12];
    assign bus.opcode_mem       = r_mem[7:4];
    assign bus.opcode_wb        = r_wb[7:4];
    assign bus.function_code_wb = r_wb[3:0];
    assign bus.stall            = w_stall;
    assign bus.halted           = r_halted;

`ifdef OPCODE_PIPE_STALL_COUNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall && !bus.flush && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign bus.stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_opcode_pipe.sv
// ============================================================================
// tb_opcode_pipe : vector table, hand sequences and a scoreboard for opcode_pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_opcode_pipe;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    opcode_pipe_if bus();

    opcode_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        flush;
        logic        stall;
        logic [3:0]  id;
        logic [3:0]  ex;
        logic [3:0]  mem;
        logic [3:0]  wb;
        logic [3:0]  fc;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] fc;
        int         due;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];

    function automatic vec_t mk(logic [15:0] i, logic v, logic f, logic s,
                                logic [3:0] id, logic [3:0] ex, logic [3:0] mem,
                                logic [3:0] wb, logic [3:0] fc);
        vec_t r;
        r.instr = i; r.valid = v; r.flush = f; r.stall = s;
        r.id = id; r.ex = ex; r.mem = mem; r.wb = wb; r.fc = fc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instr_in = 16'h0; bus.instr_valid = 1'b0; bus.flush = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cyc(input logic [15:0] i, input logic v, input logic f);
        bus.instr_in = i; bus.instr_valid = v; bus.flush = f;
        @(posedge clk);
        #1;
        bus.instr_in = 16'h0; bus.instr_valid = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int n);
        bus.instr_in = v.instr; bus.instr_valid = v.valid; bus.flush = v.flush;
        #1 chk($sformatf("v%0d.stall", n), {15'h0, bus.stall}, {15'h0, v.stall});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.id", n),  {12'h0, bus.opcode_id},  {12'h0, v.id});
        chk($sformatf("v%0d.ex", n),  {12'h0, bus.opcode_ex},  {12'h0, v.ex});
        chk($sformatf("v%0d.mem", n), {12'h0, bus.opcode_mem}, {12'h0, v.mem});
        chk($sformatf("v%0d.wb", n),  {12'h0, bus.opcode_wb},  {12'h0, v.wb});
        chk($sformatf("v%0d.fc", n),  {12'h0, bus.function_code_wb}, {12'h0, v.fc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc_n;
        logic [15:0] ins;
        logic        v;
        sb_t         e;

        checks = 0; failures = 0;

        // Latency, invalid-to-bubble
        vecs.push_back(mk(16'h1234,1,0,0, 4'h1,4'h8,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h6355,0,0,0, 4'h8,4'h1,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h1,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h1,4'h4));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h8,4'h0));
        // LW load-use on op2, fetched 2000 during stall must be dropped
        vecs.push_back(mk(16'h6300,1,0,0, 4'h6,4'h8,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h1430,1,0,0, 4'h1,4'h6,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h2000,1,0,1, 4'h1,4'h8,4'h6,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h1,4'h8,4'h6,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h1,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h1,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h8,4'h0));
        // No register match
        vecs.push_back(mk(16'h6300,1,0,0, 4'h6,4'h8,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h1450,1,0,0, 4'h1,4'h6,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h1,4'h6,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h1,4'h6,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h1,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h8,4'h0));
        // Branch flush
        vecs.push_back(mk(16'hC120,1,0,0, 4'hC,4'h8,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h1111,1,0,0, 4'h1,4'hC,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h2222,1,1,0, 4'h8,4'h8,4'hC,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'hC,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h8,4'h0));
        // Flush masks a pending stall
        vecs.push_back(mk(16'h6300,1,0,0, 4'h6,4'h8,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h1430,1,0,0, 4'h1,4'h6,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,1,0, 4'h8,4'h8,4'h6,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h6,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h8,4'h0));
        // LBU load-use on op1, func rides with opcode to WB
        vecs.push_back(mk(16'h4500,1,0,0, 4'h4,4'h8,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h3567,1,0,0, 4'h3,4'h4,4'h8,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,1, 4'h3,4'h8,4'h4,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h3,4'h8,4'h4,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h3,4'h8,4'h0));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h3,4'h7));
        vecs.push_back(mk(16'h0000,0,0,0, 4'h8,4'h8,4'h8,4'h8,4'h0));

        do_reset();
        chk("rst.id",  {12'h0, bus.opcode_id},  16'h8);
        chk("rst.ex",  {12'h0, bus.opcode_ex},  16'h8);
        chk("rst.mem", {12'h0, bus.opcode_mem}, 16'h8);
        chk("rst.wb",  {12'h0, bus.opcode_wb},  16'h8);
        chk("rst.fc",  {12'h0, bus.function_code_wb}, 16'h0);
        chk("rst.stall",  {15'h0, bus.stall},  16'h0);
        chk("rst.halted", {15'h0, bus.halted}, 16'h0);

        for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);

        // HALT drain
        do_reset();
        cyc(16'h1123, 1'b1, 1'b0);
        cyc(16'hF000, 1'b1, 1'b0);
        chk("halt.id0", {12'h0, bus.opcode_id}, 16'hF);
        chk("halt.ex0", {12'h0, bus.opcode_ex}, 16'h1);
        cyc(16'h5555, 1'b1, 1'b0);
        chk("halt.id1",  {12'h0, bus.opcode_id},  16'hF);
        chk("halt.ex1",  {12'h0, bus.opcode_ex},  16'h8);
        chk("halt.mem1", {12'h0, bus.opcode_mem}, 16'h1);
        chk("halt.h1",   {15'h0, bus.halted},     16'h0);
        cyc(16'h5555, 1'b1, 1'b0);
        chk("halt.wb2", {12'h0, bus.opcode_wb}, 16'h1);
        chk("halt.fc2", {12'h0, bus.function_code_wb}, 16'h3);
        chk("halt.h2",  {15'h0, bus.halted}, 16'h0);
        cyc(16'h0000, 1'b0, 1'b0);
        chk("halt.wb3", {12'h0, bus.opcode_wb}, 16'h8);
        chk("halt.h3",  {15'h0, bus.halted}, 16'h1);
        cyc(16'h7777, 1'b1, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0);
        chk("halt.id5", {12'h0, bus.opcode_id}, 16'hF);
        chk("halt.ex5", {12'h0, bus.opcode_ex}, 16'h8);
        chk("halt.h5",  {15'h0, bus.halted}, 16'h1);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("arst.id", {12'h0, bus.opcode_id}, 16'h8);
        chk("arst.halted", {15'h0, bus.halted}, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // HALT in ID overrides a load-use match
        cyc(16'h6300, 1'b1, 1'b0);
        cyc(16'hF300, 1'b1, 1'b0);
        chk("hstall.stall", {15'h0, bus.stall}, 16'h0);
        cyc(16'h0000, 1'b0, 1'b0);
        chk("hstall.id", {12'h0, bus.opcode_id}, 16'hF);
        chk("hstall.ex", {12'h0, bus.opcode_ex}, 16'h8);

        // Flush removes HALT from ID
        do_reset();
        cyc(16'h1123, 1'b1, 1'b0);
        cyc(16'hF000, 1'b1, 1'b0);
        cyc(16'h0000, 1'b0, 1'b1);
        chk("fhalt.id",  {12'h0, bus.opcode_id},  16'h8);
        chk("fhalt.ex",  {12'h0, bus.opcode_ex},  16'h8);
        chk("fhalt.mem", {12'h0, bus.opcode_mem}, 16'h1);
        for (int k = 0; k < 4; k++) begin
            cyc(16'h0000, 1'b0, 1'b0);
            chk($sformatf("fhalt.h%0d", k), {15'h0, bus.halted}, 16'h0);
        end

`ifdef OPCODE_PIPE_STALL_COUNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(16'h6300, 1'b1, 1'b0);
            cyc(16'h1430, 1'b1, 1'b0);
            cyc(16'h0000, 1'b0, 1'b0);
            cyc(16'h0000, 1'b0, 1'b0);
        end
        chk("scnt.three", bus.stall_count, 16'd3);
        #2 rst = 1'b1;
        #1 chk("scnt.rst", bus.stall_count, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        // Scoreboard: random non-load, non-halt stream, each op due 4 cycles later
        do_reset();
        cyc_n = 0;
        for (int i = 0; i < 46; i++) begin
            ins = 16'($urandom);
            while (ins[15:12] == 4'h4 || ins[15:12] == 4'h6 ||
                   ins[15:12] == 4'h8 || ins[15:12] == 4'hF)
                ins[15:12] = 4'($urandom_range(0, 15));
            v = (i < 40) && ($urandom_range(0, 3) != 0);
            if (v) begin
                e.op = ins[15:12]; e.fc = ins[3:0]; e.due = cyc_n + 4;
                sbq.push_back(e);
            end
            cyc(ins, v, 1'b0);
            cyc_n++;
            if (sbq.size() > 0 && sbq[0].due == cyc_n) begin
                e = sbq.pop_front();
                chk($sformatf("sb%0d.wb", cyc_n), {12'h0, bus.opcode_wb}, {12'h0, e.op});
                chk($sformatf("sb%0d.fc", cyc_n), {12'h0, bus.function_code_wb}, {12'h0, e.fc});
            end else begin
                chk($sformatf("sb%0d.idle", cyc_n), {12'h0, bus.opcode_wb}, 16'h8);
            end
        end
        chk("sb.empty", 16'(sbq.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
